// File: rtl/dvp_cam_tx.sv
// DVP camera-side transmitter: 16-bit pixel stream -> 8-bit cmos_data/href/vsyn bus,
// high byte first, with parameterised vsync / porch / blanking timing.
module dvp_cam_tx #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int VS_CYCLES  = 3,
  parameter int VBP_CYCLES = 2,
  parameter int HB_CYCLES  = 3,
  parameter int VFP_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  cmos_data,
  output logic        cmos_href,
  output logic        cmos_vsyn,
  output logic        frame_start,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LINE_BYTES = 2 * H_ACTIVE;
  localparam int MAXC = max2(max2(max2(VS_CYCLES, VBP_CYCLES), max2(HB_CYCLES, VFP_CYCLES)),
                             LINE_BYTES);
  localparam int CW = $clog2(MAXC + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);

  localparam logic [CW-1:0] VS_L  = CW'(VS_CYCLES - 1);
  localparam logic [CW-1:0] VBP_L = CW'(VBP_CYCLES - 1);
  localparam logic [CW-1:0] LB_L  = CW'(LINE_BYTES - 1);
  localparam logic [CW-1:0] HB_L  = CW'(HB_CYCLES - 1);
  localparam logic [CW-1:0] VFP_L = CW'(VFP_CYCLES - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, LINE, HBLANK, VFP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] line;
  logic [7:0]    lo_byte;

  // In LINE, cnt is the byte index; odd cnt is a low-byte cycle, so the byte phase is cnt[0].
  // A pixel is taken one cycle ahead of every high-byte cycle.
  assign pix_ready = (state == VBP    && cnt == VBP_L) ||
                     (state == LINE   && cnt[0] && cnt != LB_L) ||
                     (state == HBLANK && cnt == HB_L && line < LAST_LINE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      line        <= '0;
      lo_byte     <= '0;
      cmos_data   <= '0;
      cmos_href   <= 1'b0;
      cmos_vsyn   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      case (state)
        IDLE: if (en) begin
          state       <= VSYNC;
          cnt         <= '0;
          cmos_vsyn   <= 1'b1;
          frame_start <= 1'b1;
        end
        VSYNC: if (cnt == VS_L) begin
          state     <= VBP;
          cnt       <= '0;
          cmos_vsyn <= 1'b0;
        end else cnt <= cnt + CW'(1);
        VBP: if (cnt == VBP_L) begin
          state <= LINE;
          cnt   <= '0;
          line  <= '0;
        end else cnt <= cnt + CW'(1);
        LINE: if (cnt == LB_L) begin
          state     <= HBLANK;
          cnt       <= '0;
          cmos_href <= 1'b0;
          cmos_data <= '0;
        end else begin
          cnt <= cnt + CW'(1);
          if (!cnt[0]) cmos_data <= lo_byte;
        end
        HBLANK: if (cnt == HB_L) begin
          cnt <= '0;
          if (line < LAST_LINE) begin
            state <= LINE;
            line  <= line + LW'(1);
          end else state <= VFP;
        end else cnt <= cnt + CW'(1);
        VFP: if (cnt == VFP_L) begin
          cnt       <= '0;
          frame_cnt <= frame_cnt + 16'd1;
          if (en) begin
            state       <= VSYNC;
            cmos_vsyn   <= 1'b1;
            frame_start <= 1'b1;
          end else state <= IDLE;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
      // Pixel hand-off overrides the LINE data path; a missing pixel goes out as 00,00.
      if (pix_ready) begin
        cmos_href <= 1'b1;
        cmos_data <= pix_valid ? pix_data[15:8] : 8'h00;
        lo_byte   <= pix_valid ? pix_data[7:0]  : 8'h00;
        underrun  <= ~pix_valid;
      end
    end
  end

endmodule

// File: doc/dvp_cam_tx.md
Name: dvp_cam_tx

Overview:
DVP camera-side transmitter that turns a stream of 16-bit pixels into the 8-bit cmos_data / cmos_href / cmos_vsyn bus our camera receiver consumes.
- Each pixel goes out as two bytes, high byte first.
- Frame timing (vsync, back porch, active lines, line blanking, front porch) comes from parameters.
- Used as a camera model in simulation and as a loopback source on hardware, fed from the pattern generator or frame buffer reader.

Parameters:
H_ACTIVE, 640, pixels per line; each line is 2*H_ACTIVE bytes with href high.
V_ACTIVE, 480, active lines per frame.
VS_CYCLES, 3, clock cycles cmos_vsyn is held high.
VBP_CYCLES, 2, idle cycles after vsync falls, before the first line.
HB_CYCLES, 3, href-low cycles after every active line, including the last.
VFP_CYCLES, 2, idle cycles after the last line's blanking, before the next vsync.
All parameters must be ≥1. Counter widths use $clog2 of the largest count.

Ports:
CLK  in  1  single clock; all outputs change on its rising edge.
RST  in  1  asynchronous, active-high reset.
en  in  1  frame enable; sampled only at frame boundaries.
pix_data  in  16  pixel; [15:8] sent first, [7:0] second.
pix_valid  in  1  pix_data valid.
pix_ready  out  1  combinational; pixel is consumed on the edge where pix_ready is high.
cmos_data  out  8  registered DVP data.
cmos_href  out  1  registered line-valid.
cmos_vsyn  out  1  registered frame sync, active high.
frame_start  out  1  registered one-cycle pulse, coincident with the first vsync cycle.
underrun  out  1  registered one-cycle pulse, coincident with the high-byte cycle of a pixel that was sent as zero.
frame_cnt  out  16  number of completed frames; wraps 65535 -> 0.

Behaviour:
- Reset (async, any time, including mid-line):
  - State goes to IDLE; all counters and the byte phase clear.
  - All outputs are 0 and hold 0 while RST is high.
  - The first frame after release starts with a full vsync.
- States: IDLE, VSYNC, VBP, LINE, HBLANK, VFP. All outputs are registered and reflect the state.
- IDLE: outputs low. If en=1, the next cycle is the first VSYNC cycle (cmos_vsyn=1, frame_start=1).
- VSYNC: cmos_vsyn=1 for exactly VS_CYCLES cycles, then VBP.
- VBP: VBP_CYCLES cycles with everything low, then LINE with line counter = 0.
- LINE:
  - cmos_href=1 for exactly 2*H_ACTIVE consecutive cycles; the byte phase alternates high, low, high, low, ...
  - pix_ready=1 only in the cycle immediately before each high-byte output cycle, i.e. H_ACTIVE cycles per line, never outside that.
  - On that edge, if pix_valid=1: cmos_data <= pix_data[15:8] and pix_data[7:0] is latched; the next cycle outputs the latched low byte.
  - If pix_valid=0 (underrun): both bytes are 0x00 and underrun pulses with the high byte. No stall; timing is never stretched.
- HBLANK: cmos_href=0 for HB_CYCLES cycles. Then:
  - if the line counter is below V_ACTIVE-1: increment it and go to LINE;
  - otherwise go to VFP.
- VFP:
  - VFP_CYCLES cycles with everything low.
  - On the last VFP cycle, frame_cnt increments (wrap allowed).
  - Next state is VSYNC if en=1 (back-to-back frames, no IDLE cycle), otherwise IDLE.
- Whenever cmos_href=0, cmos_data=0x00. cmos_vsyn and cmos_href are never high together.
- en deasserted mid-frame: the current frame completes fully, then IDLE. en pulses while not in IDLE/VFP-end are ignored.
- Frame length in cycles: VS + VBP + V_ACTIVE*(2*H_ACTIVE + HB) + VFP.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, VS=3, VBP=2, HB=3, VFP=2; upstream always valid with an incrementing pixel from 0x1234 unless stated):
1. Release RST, en=1 → frame_start and cmos_vsyn rise together, vsyn high 3 cycles, 2 idle cycles, then 8 href cycles with bytes 12,34,12,35,12,36,12,37 → 3 href-low cycles → second line 12,38..12,3B.
2. en held high → vsync of frame 2 starts exactly 29 cycles after frame 1's; frame_cnt reads 1 after the first VFP, 2 after the second; no IDLE cycle between frames.
3. pix_valid=0 for the third pixel of line 0 → that pixel's bytes are 00,00, underrun pulses once on its high-byte cycle, href width stays 8, the following pixel resumes with the next upstream value.
4. Count pix_ready cycles over one frame → exactly 8; each is followed one cycle later by an href-high high-byte cycle.
5. Drop en during line 1 → the frame finishes through VFP, then IDLE with outputs low; raising en again gives frame_start on the cycle after.
6. Assert RST asynchronously mid-line (between clock edges) → all outputs 0 immediately. After release with en=1 → a full 3-cycle vsync, frame_cnt=0.
